// File: rtl/fl_f_pipe.sv
// float32 -> signed Q1.FRAC_W converter, two-stage elastic pipeline (unpack/shift, then sign apply).
// Each stage advances when its downstream slot is free, so the skid-free chain never drops or duplicates.
module fl_f_pipe #(
    parameter int FIX_W  = 22,
    parameter int FRAC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      float_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FIX_W-1:0] fixed_out,
    output logic [1:0]       out_flags
);
    // Smallest exponent that still yields a nonzero LSB, and the shift base aligning M to FRAC_W bits.
    localparam logic [7:0]       EXP_MIN    = 8'(127 - FRAC_W);
    localparam logic [7:0]       SHIFT_BASE = 8'(150 - FRAC_W);
    localparam logic [FIX_W-1:0] SAT_POS    = {1'b0, {(FIX_W-1){1'b1}}};
    localparam logic [FIX_W-1:0] SAT_NEG    = {1'b1, {(FIX_W-1){1'b0}}};

    logic             w_sign;
    logic [7:0]       w_exp;
    logic [22:0]      w_frac;
    logic [23:0]      w_man;
    logic [7:0]       w_shamt;
    logic             w_nan;
    logic             w_sat;
    logic [FIX_W-1:0] w_mag;
    logic [FIX_W-1:0] w_neg;
    logic [FIX_W-1:0] w_fixed;
    logic             w_adv1;
    logic             w_adv2;

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic             r_s1_nan;
    logic             r_s1_sat;
    logic [FIX_W-1:0] r_s1_mag;
    logic             r_s2_valid;
    logic [FIX_W-1:0] r_fixed;
    logic [1:0]       r_flags;

    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    assign w_sign  = float_in[31];
    assign w_exp   = float_in[30:23];
    assign w_frac  = float_in[22:0];
    assign w_man   = {1'b1, w_frac};
    assign w_shamt = SHIFT_BASE - w_exp;

    // Zero and denormals fall into the exp < EXP_MIN branch and flush to 0.
    always_comb begin
        w_nan = 1'b0;
        w_sat = 1'b0;
        w_mag = '0;
        if (w_exp == 8'hFF && w_frac != '0)
            w_nan = 1'b1;
        else if (w_exp >= 8'd128)
            w_sat = 1'b1;
        else if (w_exp >= EXP_MIN)
            w_mag = FIX_W'(w_man >> w_shamt);
    end

    assign w_neg   = -r_s1_mag;
    assign w_fixed = r_s1_sat  ? (r_s1_sign ? SAT_NEG : SAT_POS) :
                     r_s1_sign ? w_neg : r_s1_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_nan   <= 1'b0;
            r_s1_sat   <= 1'b0;
            r_s1_mag   <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= w_sign;
                r_s1_nan  <= w_nan;
                r_s1_sat  <= w_sat;
                r_s1_mag  <= w_mag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_fixed    <= '0;
            r_flags    <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_fixed <= w_fixed;
                r_flags <= {r_s1_nan, r_s1_sat};
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign fixed_out = r_fixed;
    assign out_flags = r_flags;
endmodule

// File: tb/tb_fl_f_pipe.sv
// Bench for fl_f_pipe: directed vector table, stall/reset sequences, and a randomized
// handshake stream scored against a real-arithmetic model of the conversion.
module tb_fl_f_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] float_in;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] fixed_out;
    logic [1:0]  out_flags;

    int n_vec = 0;
    int n_mis = 0;

    fl_f_pipe #(.FIX_W(22), .FRAC_W(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .float_in(float_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .fixed_out(fixed_out), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        logic [21:0] fx;
        logic [1:0]  fl;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Decode the float as a real number, scale by 2^20, truncate toward zero, clamp to [-2,2).
    function automatic logic [23:0] ref_model(input logic [31:0] b);
        int  e;
        int  p;
        int  iv;
        real v;
        e = int'(b[30:23]);
        if (e == 255 && b[22:0] != 0) return {2'b10, 22'h000000};
        if (e == 255) return b[31] ? {2'b01, 22'h200000} : {2'b01, 22'h1FFFFF};
        v = (e == 0) ? real'(int'(b[22:0])) : real'(int'({1'b1, b[22:0]}));
        p = (e == 0) ? -149 : e - 150;
        if (p > 0) for (int k = 0; k < p; k++) v = v * 2.0;
        else       for (int k = 0; k < -p; k++) v = v / 2.0;
        if (b[31]) v = -v;
        if (v >= 2.0)  return {2'b01, 22'h1FFFFF};
        if (v <= -2.0) return {2'b01, 22'h200000};
        iv = $rtoi(v * 1048576.0);
        return {2'b00, iv[21:0]};
    endfunction

    function automatic logic [31:0] rnd_float();
        int         k;
        logic [7:0] e;
        k = int'($urandom_range(0, 9));
        if (k < 7)       e = 8'($urandom_range(100, 130));
        else if (k == 7) e = 8'd0;
        else if (k == 8) e = 8'd255;
        else             e = 8'($urandom);
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    logic [23:0] q[$];
    logic [23:0] exp_o;
    logic [31:0] t4[5];

    initial begin
        tbl[0]  = '{32'h3F800000, 22'h100000, 2'b00};
        tbl[1]  = '{32'h3F490FDB, 22'h0C90FD, 2'b00};
        tbl[2]  = '{32'hBF000000, 22'h380000, 2'b00};
        tbl[3]  = '{32'h00000000, 22'h000000, 2'b00};
        tbl[4]  = '{32'h40000000, 22'h1FFFFF, 2'b01};
        tbl[5]  = '{32'hFF800000, 22'h200000, 2'b01};
        tbl[6]  = '{32'h7FC00000, 22'h000000, 2'b10};
        tbl[7]  = '{32'h33800000, 22'h000000, 2'b00};
        tbl[8]  = '{32'h35800000, 22'h000001, 2'b00};
        tbl[9]  = '{32'h80000000, 22'h000000, 2'b00};
        tbl[10] = '{32'hC0000000, 22'h200000, 2'b01};
        tbl[11] = '{32'h3FFFFFFF, 22'h1FFFFF, 2'b00};
        tbl[12] = '{32'hBFFFFFFF, 22'h200001, 2'b00};
        tbl[13] = '{32'hFFC00000, 22'h000000, 2'b10};
        t4[0] = 32'h3F800000; t4[1] = 32'hBF000000; t4[2] = 32'h3F490FDB;
        t4[3] = 32'h40000000; t4[4] = 32'h35800000;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; float_in = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fixed", fixed_out, 0);
        chk("rst_flags", out_flags, 0);
        @(negedge clk); rst_n = 1'b1;

        // Directed table, back-to-back with out_ready high: result i appears in cycle i+2, no gaps.
        for (int c = 0; c <= NV + 2; c++) begin
            @(posedge clk); #1;
            in_valid  = (c < NV);
            float_in  = (c < NV) ? tbl[c].f : 32'h0;
            out_ready = 1'b1;
            @(negedge clk);
            if (c < NV) chk($sformatf("tbl_in_ready[%0d]", c), in_ready, 1);
            if (c >= 2 && c - 2 < NV) begin
                chk($sformatf("tbl_valid[%0d]", c - 2), out_valid, 1);
                chk($sformatf("tbl_fixed[%0d]", c - 2), fixed_out, tbl[c-2].fx);
                chk($sformatf("tbl_flags[%0d]", c - 2), out_flags, tbl[c-2].fl);
            end else begin
                chk($sformatf("tbl_idle[%0d]", c), out_valid, 0);
            end
        end

        // Mid-stream stall: capacity is two, outputs hold while stalled and arrive once each, in order.
        begin
            int ai = 0;
            int oi = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                in_valid  = (ai < 5);
                float_in  = (ai < 5) ? t4[ai] : 32'h0;
                out_ready = !(c >= 1 && c <= 4);
                @(negedge clk);
                if (c == 2) begin
                    chk("t4_in_ready_full", in_ready, 0);
                    chk("t4_accepted", ai, 2);
                end
                if (out_valid) begin
                    if (oi < 5) begin
                        exp_o = ref_model(t4[oi]);
                        chk($sformatf("t4_fixed[%0d]", oi), fixed_out, exp_o[21:0]);
                        chk($sformatf("t4_flags[%0d]", oi), out_flags, exp_o[23:22]);
                    end else begin
                        chk("t4_extra_out", oi, 4);
                    end
                    if (out_ready) oi++;
                end
                if (in_valid && in_ready) ai++;
            end
            chk("t4_out_count", oi, 5);
        end

        // Randomized handshake stream against the model.
        begin
            logic        stalled = 1'b0;
            logic [23:0] held = '0;
            for (int c = 0; c < 600; c++) begin
                @(posedge clk); #1;
                in_valid  = (c < 580) && ($urandom_range(0, 3) != 0);
                float_in  = rnd_float();
                out_ready = (c >= 580) || ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (stalled) begin
                    chk("rnd_hold_valid", out_valid, 1);
                    chk("rnd_hold_data", {out_flags, fixed_out}, held);
                end
                stalled = out_valid && !out_ready;
                held    = {out_flags, fixed_out};
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("rnd_unexpected_out", {out_flags, fixed_out}, 32'hDEAD);
                    else chk("rnd_out", {out_flags, fixed_out}, q.pop_front());
                end
                if (in_valid && in_ready) q.push_back(ref_model(float_in));
            end
            chk("rnd_drained", q.size(), 0);
        end

        // Reset between edges with two samples in flight.
        @(posedge clk); #1;
        in_valid = 1'b1; float_in = 32'h3F490FDB; out_ready = 1'b0;
        @(posedge clk); #1;
        float_in = 32'hBF000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        chk("t6_full_before", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        chk("t6_rst_fixed", fixed_out, 0);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; float_in = 32'h3F800000;
        @(negedge clk);
        chk("t6_lat0", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_lat1", out_valid, 0);
        @(negedge clk);
        chk("t6_lat2_valid", out_valid, 1);
        chk("t6_lat2_fixed", fixed_out, 22'h100000);
        chk("t6_lat2_flags", out_flags, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
